// File: rtl/aes_pkg.sv
// Shared AES types and byte helpers for the decryption datapath.
// Byte 0 of a state is the most significant byte (FIPS-197 order).
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic byte_t get_byte(input state_t s, input int idx);
    return s[127 - 8*idx -: 8];
  endfunction

  function automatic state_t set_byte(input state_t s, input int idx, input byte_t b);
    state_t r;
    r = s;
    r[127 - 8*idx -: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box as a combinational lookup; TBL[a] is InvSbox(a).
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);

  localparam logic [0:255][7:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign q = TBL[a];

endmodule

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed InvSubBytes: LANES shared inverse S-boxes process the
// 16 state bytes over 16/LANES cycles between two valid/ready handshakes.
module inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NGRP = 16 / LANES;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NGRP - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sub_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  state_t        src_reg, src_next;
  state_t        res_reg, res_next;
  byte_t         lane_in  [LANES];
  byte_t         lane_out [LANES];
  logic          in_ready_c;

  // Lane gi handles byte cnt*LANES+gi of the current group.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_in[gi] = get_byte(src_reg, int'(cnt_reg) * LANES + gi);
      inv_sbox u_sbox (
        .a (lane_in[gi]),
        .q (lane_out[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      src_reg   <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      src_reg   <= src_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    src_next   = src_reg;
    res_next   = res_reg;
    in_ready_c = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          src_next   = in_state;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          res_next = set_byte(res_next, int'(cnt_reg) * LANES + l, lane_out[l]);
        end
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Combinational out_ready -> in_ready allows a same-cycle hand-off.
        in_ready_c = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            src_next   = in_state;
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = in_ready_c & ~rst;
  assign out_state = res_reg;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed and random checks of inv_subbytes_seq across all legal LANES
// values; the reference InvSbox is derived from GF(2^8) arithmetic.
module tb_inv_subbytes_seq;

  localparam int NI   = 5;
  localparam int MAIN = 2;  // LANES = 4 instance

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv = 1'b0;
  logic         ordy = 1'b0;
  logic [127:0] ist = '0;
  logic         ir [NI];
  logic         ov [NI];
  logic         bz [NI];
  logic [127:0] os [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    inv_subbytes_seq #(.LANES(1 << gi)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir[gi]),
      .in_state  (ist),
      .out_valid (ov[gi]),
      .out_ready (ordy),
      .out_state (os[gi]),
      .busy      (bz[gi])
    );
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] inv_tbl [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box from GF inverse + affine map, then inverted into inv_tbl.
  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv_tbl[s[127 - 8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One state through the main instance; lat counts edges after the accept edge.
  task automatic run_one(input logic [127:0] s, output logic [127:0] r, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ir[MAIN] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    iv  = 1'b1;
    ist = s;
    @(posedge clk);
    @(negedge clk);
    iv  = 1'b0;
    ist = rnd128();
    lat = 0;
    while (!ov[MAIN] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = os[MAIN];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r;
    int           lat;
    int           lats [NI];
    logic [127:0] outs [NI];
    logic [127:0] b2b_in [3];
    logic [127:0] b2b_exp [3];
    int           acc_cyc [3];
    int           nacc, nout, nin, cyc;
    logic [127:0] sb [$];
    logic [127:0] held;
    logic         prev_stall, acc_last;

    build_model();

    vecs[0] = '{din: {16{8'h63}}, dout: 128'h0};
    vecs[1] = '{din: 128'h000102030405060708090a0b0c0d0e0f, dout: 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[2] = '{din: 128'h101112131415161718191a1b1c1d1e1f, dout: 128'h7ce339829b2fff87348e4344c4dee9cb};
    vecs[3] = '{din: 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, dout: 128'h172b047eba77d626e169146355210c7d};
    vecs[4] = '{din: {16{8'h7c}}, dout: {16{8'h01}}};
    vecs[5] = '{din: {16{8'h16}}, dout: {16{8'hff}}};
    vecs[6] = '{din: {16{8'hff}}, dout: {16{8'h7d}}};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 128'(ir[MAIN]), 128'd0);
    chk("rst_out_valid", 128'(ov[MAIN]), 128'd0);
    chk("rst_busy", 128'(bz[MAIN]), 128'd0);
    chk("rst_out_state", os[MAIN], 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(ir[MAIN]), 128'd1);

    // Table of directed vectors, downstream always ready
    ordy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].din, r, lat);
      $display("vec %0d: in=%h out=%h lat=%0d", i, vecs[i].din, r, lat);
      chk("vec_out", r, vecs[i].dout);
      chk("vec_lat", 128'(lat), 128'd4);
    end

    // Latency for every legal LANES value
    do_reset();
    ordy = 1'b1;
    iv   = 1'b1;
    ist  = 128'h000102030405060708090a0b0c0d0e0f;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    for (int i = 0; i < NI; i++) lats[i] = -1;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < NI; i++)
        if (ov[i] && lats[i] < 0) begin
          lats[i] = c;
          outs[i] = os[i];
        end
      @(negedge clk);
    end
    for (int i = 0; i < NI; i++) begin
      $display("lanes %0d: out=%h lat=%0d", 1 << i, outs[i], lats[i]);
      chk("lanes_lat", 128'(lats[i]), 128'(16 >> i));
      chk("lanes_out", outs[i], 128'h52096ad53036a538bf40a39e81f3d7fb);
    end

    // Back-pressure: result held, input ignored
    do_reset();
    ordy = 1'b0;
    iv   = 1'b1;
    ist  = '0;
    @(posedge clk);
    @(negedge clk);
    iv  = 1'b0;
    lat = 0;
    while (!ov[MAIN] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 128'(lat), 128'd4);
    for (int c = 0; c < 10; c++) begin
      iv  = c[0];
      ist = rnd128();
      #1;
      $display("bp cycle %0d: in_valid=%0b out=%h in_ready=%0b", c, iv, os[MAIN], ir[MAIN]);
      chk("bp_out", os[MAIN], {16{8'h52}});
      chk("bp_in_ready", 128'(ir[MAIN]), 128'd0);
      chk("bp_out_valid", 128'(ov[MAIN]), 128'd1);
      @(negedge clk);
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_valid", 128'(ov[MAIN]), 128'd0);
    chk("bp_release_ready", 128'(ir[MAIN]), 128'd1);

    // Back-to-back stream
    do_reset();
    b2b_in[0]  = {16{8'h7c}};
    b2b_in[1]  = {16{8'h16}};
    b2b_in[2]  = {16{8'h63}};
    b2b_exp[0] = {16{8'h01}};
    b2b_exp[1] = {16{8'hff}};
    b2b_exp[2] = '0;
    ordy = 1'b1;
    iv   = 1'b1;
    ist  = b2b_in[0];
    nacc = 0;
    nout = 0;
    cyc  = 0;
    while (nout < 3 && cyc < 200) begin
      #1;
      if (ov[MAIN] && ordy) begin
        $display("b2b out %0d: %h cycle=%0d", nout, os[MAIN], cyc);
        chk("b2b_out", os[MAIN], b2b_exp[nout]);
        nout++;
      end
      if (iv && ir[MAIN] && nacc < 3) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
      cyc++;
      if (nacc < 3) ist = b2b_in[nacc];
      else iv = 1'b0;
    end
    chk("b2b_count", 128'(nout), 128'd3);
    chk("b2b_gap1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd5);
    chk("b2b_gap2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd5);

    // Reset in the second RUN cycle
    ordy = 1'b1;
    @(negedge clk);
    iv  = 1'b1;
    ist = {16{8'h16}};
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    chk("mid_busy", 128'(bz[MAIN]), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("mid reset: out_valid=%0b out=%h in_ready=%0b", ov[MAIN], os[MAIN], ir[MAIN]);
    chk("mid_rst_valid", 128'(ov[MAIN]), 128'd0);
    chk("mid_rst_out", os[MAIN], 128'd0);
    chk("mid_rst_ready", 128'(ir[MAIN]), 128'd1);
    chk("mid_rst_busy", 128'(bz[MAIN]), 128'd0);
    run_one({16{8'h7c}}, r, lat);
    chk("mid_after_out", r, {16{8'h01}});
    chk("mid_after_lat", 128'(lat), 128'd4);

    // Random stream with stalls against the scoreboard
    do_reset();
    nin        = 0;
    nout       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    acc_last   = 1'b0;
    held       = '0;
    while (nout < 1000 && cyc < 60000) begin
      if (!iv || acc_last) begin
        if (nin < 1000 && $urandom_range(0, 3) != 0) begin
          iv  = 1'b1;
          ist = rnd128();
        end else begin
          iv = 1'b0;
        end
      end
      ordy = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        chk("rnd_hold_valid", 128'(ov[MAIN]), 128'd1);
        chk("rnd_hold_out", os[MAIN], held);
      end
      if (ov[MAIN] && ordy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_extra: got %h want no output", os[MAIN]);
        end else begin
          $display("rnd out %0d: %h", nout, os[MAIN]);
          chk("rnd_out", os[MAIN], sb.pop_front());
        end
        nout++;
      end
      prev_stall = ov[MAIN] && !ordy;
      held       = os[MAIN];
      acc_last   = iv && ir[MAIN];
      if (acc_last) begin
        sb.push_back(inv_sub(ist));
        nin++;
      end
      @(negedge clk);
      cyc++;
    end
    iv = 1'b0;
    chk("rnd_count", 128'(nout), 128'd1000);
    chk("rnd_left", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_subbytes_seq.md
# inv_subbytes_seq

Time-multiplexed InvSubBytes engine for the decryption datapath. It accepts a 128-bit AES state over a valid/ready handshake and pushes the state's 16 bytes through `LANES` shared `inv_sbox` instances over `16/LANES` cycles. It returns the substituted state over a second valid/ready handshake. It sits between the round controller and InvShiftRows/InvMixColumns, and trades area against latency.

## Interface
- `LANES`, default 4: number of parallel `inv_sbox` instances. Legal values are 1, 2, 4, 8 and 16; any other value fails elaboration.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `in_state` is valid.
- `in_ready` out 1: the block can accept a state.
- `in_state` in 128: input state; byte k is `in_state[127-8k -: 8]` (byte 0 is the MSB, FIPS-197 order).
- `out_valid` out 1: `out_state` holds a completed result.
- `out_ready` in 1: the downstream block accepts the result.
- `out_state` out 128: substituted state, in the same byte order as `in_state`.
- `busy` out 1: high in RUN.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1.
  - Accept (`in_valid & in_ready`): register `in_state` into `src`, clear `cnt`, go to RUN.
- RUN:
  - `in_ready`=0.
  - Each cycle, bytes `cnt*LANES` to `cnt*LANES+LANES-1` of `src` drive the lanes. The lane outputs are written into the same byte positions of `res`.
  - `cnt` increments. When `cnt == 16/LANES-1`, the final group is written, `cnt` clears and the FSM goes to DONE.
- DONE:
  - `out_valid`=1, `out_state`=`res`, held stable until `out_ready`.
  - `in_ready` = `out_ready`. This allows a back-to-back hand-off.
  - `out_ready & in_valid`: the result is consumed and the new state is captured into `src` in the same cycle. `cnt` clears and the FSM goes to RUN.
  - `out_ready & !in_valid`: go to IDLE.
- Width rules:
  - `cnt` is `$clog2(16/LANES)` bits, minimum 1 bit.
  - For `LANES`=16, RUN lasts exactly one cycle.
- `res` bytes not yet written in the current operation hold stale data. They are never visible, because `out_valid` is low outside DONE.
- `in_state` is sampled only on accept; changes outside accept have no effect.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after reset; `out_valid`=0; `busy`=0; `out_state`=0; FSM in IDLE; `cnt`=0.
- Latency:
  - Accept at edge N puts the FSM in RUN for cycles N+1 to N+16/LANES.
  - `out_valid` rises after edge N+16/LANES.
  - `LANES`=4 gives 4 RUN cycles, with `out_valid` in the 5th cycle after accept.
- Throughput with a downstream that is always ready is one state per `16/LANES`+1 cycles, using the DONE to RUN hand-off.
- Back-pressure: while `out_ready`=0 the block remains in DONE indefinitely and `out_state` does not change.
- `rst` asserted in any state, including mid-RUN, aborts the operation on that edge with no partial output. All reset values apply from the next cycle.
- No combinational path exists from `in_valid` to `out_valid`.
- There is one combinational path, from `out_ready` to `in_ready`, and only in DONE. It is documented for integration.

## Structure
- Shared package `aes_pkg`:
  - `state_t` (128-bit).
  - `byte_t` (8-bit).
  - FSM enum `sub_state_e` {IDLE, RUN, DONE}.
  - Function `get_byte(state_t, idx)` and its matching byte-set function.
- Sub-module: `inv_sbox`, instantiated `LANES` times in a generate loop. Its input is muxed from `src` by `cnt` and lane index.
- Expected implementation size is about 150 lines excluding the sbox.

## Test plan
- Reset, then drive `in_state` = 16×0x63 with `in_valid`=1 and `out_ready`=1:
  - `out_state` = 0.
  - `out_valid` appears exactly `16/LANES`+1 cycles after accept.
- `in_state` = 0x000102030405060708090a0b0c0d0e0f:
  - `out_state` = 0x52096ad53036a538bf40a39e81f3d7fb.
  - Repeat for `LANES` = 1, 2, 4, 8 and 16, checking that latency equals `16/LANES`.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE with input 16×0x00.
  - `out_state` stays 16×0x52.
  - `in_ready` stays 0.
  - `in_valid` toggling has no effect.
- Back-to-back: stream 3 states (16×0x7c, 16×0x16, 16×0x63) with `out_ready`=1.
  - Outputs are 16×0x01, 16×0xff, 16×0x00.
  - Accepts are `16/LANES`+1 cycles apart.
- Assert `rst` in the second RUN cycle:
  - Next cycle: IDLE, `out_valid`=0, `out_state`=0, `in_ready`=1.
  - A new input then completes correctly.
- Random: 1000 random states with random `in_valid`/`out_ready` stalls are compared against a software InvSubBytes model.
  - No result is lost or duplicated.
  - `out_state` is stable whenever `out_valid & !out_ready`.
